// File: rtl/ram_sized_access_ctrl_if.sv
// Request/response bus between the control unit's memory interface and the
// sized-access data RAM controller. The master holds Enable until it sees MOC.
interface ram_sized_access_ctrl_if;
  logic        Enable;
  logic        ReadWrite;
  logic [1:0]  Size;
  logic        Signed;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        Busy;
  logic        AddrErr;

  modport master (
    output Enable, ReadWrite, Size, Signed, Address, DataIn,
    input  DataOut, MOC, Busy, AddrErr
  );

  modport slave (
    input  Enable, ReadWrite, Size, Signed, Address, DataIn,
    output DataOut, MOC, Busy, AddrErr
  );
endinterface

// File: rtl/ram_sized_access_ctrl.sv
// Byte-wide data RAM with big-endian byte/halfword/word access, programmable
// wait states, an Enable/MOC handshake, read extension and address faulting.
module ram_sized_access_ctrl #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 1
) (
  input logic                   Clk,
  input logic                   Reset,
  ram_sized_access_ctrl_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01,
                            SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_t;

  logic [7:0] mem [DEPTH];

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rw_q, rw_d;
  size_t       size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] din_q, din_d;
  logic [31:0] dout_q, dout_d;
  logic        moc_q, moc_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_h1, idx_w1, idx_w2, idx_w3;
  logic              fault;
  logic              access_now;
  logic              mem_we;
  logic [31:0]       rd_data;

  // Byte lanes of the latched access: aligned accesses never carry across
  // the low address bits, so neighbours are formed by OR-ing in the offset.
  assign idx    = addr_q[ADDR_W-1:0];
  assign idx_h1 = {idx[ADDR_W-1:1], 1'b1};
  assign idx_w1 = {idx[ADDR_W-1:2], 2'b01};
  assign idx_w2 = {idx[ADDR_W-1:2], 2'b10};
  assign idx_w3 = {idx[ADDR_W-1:2], 2'b11};

  // Fault decode on the latched request: misalignment, out of range, reserved size.
  always_comb begin
    fault = ((addr_q >> ADDR_W) != 32'd0);
    unique case (size_q)
      SZ_HALF: if (addr_q[0])          fault = 1'b1;
      SZ_WORD: if (addr_q[1:0] != 2'd0) fault = 1'b1;
      SZ_RSVD:                          fault = 1'b1;
      default: ;
    endcase
  end

  assign access_now = (state_q == S_WAIT) && (cnt_q == 4'd0);
  assign mem_we     = access_now && !fault && !rw_q;

  // Big-endian read assembly with zero/sign extension of byte and halfword.
  always_comb begin
    rd_data = 32'd0;
    unique case (size_q)
      SZ_BYTE: rd_data = {{24{signed_q & mem[idx][7]}}, mem[idx]};
      SZ_HALF: rd_data = {{16{signed_q & mem[idx][7]}}, mem[idx], mem[idx_h1]};
      SZ_WORD: rd_data = {mem[idx], mem[idx_w1], mem[idx_w2], mem[idx_w3]};
      default: rd_data = 32'd0;
    endcase
  end

  // Handshake FSM next state: accept in IDLE, count in WAIT, hold in DONE.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rw_d     = rw_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dout_d   = dout_q;
    moc_d    = moc_q;
    busy_d   = busy_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Enable) begin
          rw_d     = bus.ReadWrite;
          size_d   = size_t'(bus.Size);
          signed_d = bus.Signed;
          addr_d   = bus.Address;
          din_d    = bus.DataIn;
          cnt_d    = 4'(WAIT_STATES);
          busy_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          moc_d   = 1'b1;
          err_d   = fault;
          state_d = S_DONE;
          if (!fault && rw_q) dout_d = rd_data;
        end
      end
      S_DONE: begin
        if (!bus.Enable) begin
          moc_d   = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rw_q     <= 1'b0;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      din_q    <= 32'd0;
      dout_q   <= 32'd0;
      moc_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rw_q     <= rw_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dout_q   <= dout_d;
      moc_q    <= moc_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Storage write of only the addressed bytes; a pending write is dropped on reset.
  always_ff @(posedge Clk) begin
    // NOTE: the array has no reset branch so it maps onto RAM; Reset only
    // gates the write enable so an aborted write never lands.
    if (mem_we && !Reset) begin
      unique case (size_q)
        SZ_BYTE: mem[idx] <= din_q[7:0];
        SZ_HALF: begin
          mem[idx]    <= din_q[15:8];
          mem[idx_h1] <= din_q[7:0];
        end
        SZ_WORD: begin
          mem[idx]    <= din_q[31:24];
          mem[idx_w1] <= din_q[23:16];
          mem[idx_w2] <= din_q[15:8];
          mem[idx_w3] <= din_q[7:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;
  assign bus.Busy    = busy_q;
  assign bus.AddrErr = err_q;

endmodule

// File: tb/tb_ram_sized_access_ctrl.sv
// Drives two controllers (1 and 3 wait states) with identical requests and
// compares both against a byte-array model of the big-endian RAM.
module tb_ram_sized_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, rw, sgn;
  logic [1:0]  sz;
  logic [31:0] addr, din;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mm [512];
  logic [31:0] exp_dout;

  always #5 clk = ~clk;

  ram_sized_access_ctrl_if bus1 ();
  ram_sized_access_ctrl_if bus3 ();

  assign bus1.Enable = en;  assign bus3.Enable = en;
  assign bus1.ReadWrite = rw; assign bus3.ReadWrite = rw;
  assign bus1.Size = sz;    assign bus3.Size = sz;
  assign bus1.Signed = sgn; assign bus3.Signed = sgn;
  assign bus1.Address = addr; assign bus3.Address = addr;
  assign bus1.DataIn = din; assign bus3.DataIn = din;

  ram_sized_access_ctrl #(.ADDR_W(9), .WAIT_STATES(1)) dut1 (
    .Clk(clk), .Reset(rst), .bus(bus1)
  );
  ram_sized_access_ctrl #(.ADDR_W(9), .WAIT_STATES(3)) dut3 (
    .Clk(clk), .Reset(rst), .bus(bus3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || (s == 2'd1 && a % 2 != 0) ||
           (s == 2'd2 && a % 4 != 0) || (a >= 32'd512);
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] s, input logic g,
                                             input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (s)
      2'd0: begin
        v = 32'(mm[a]);
        if (g && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end
      2'd1: begin
        v = 32'(mm[a]) * 256 + 32'(mm[a + 1]);
        if (g && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      default: v = 32'(mm[a]) * 16777216 + 32'(mm[a + 1]) * 65536 +
                   32'(mm[a + 2]) * 256 + 32'(mm[a + 3]);
    endcase
    return v;
  endfunction

  task automatic model_write(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    int nb;
    nb = 1 << s;
    for (int i = 0; i < nb; i++) mm[a + i] = 8'(d >> (8 * (nb - 1 - i)));
  endtask

  // One complete request on both controllers, with inputs scrambled after acceptance.
  task automatic access(input logic r, input logic [1:0] s, input logic g,
                        input logic [31:0] a, input logic [31:0] d, input string tag);
    logic exp_err;
    int lat1, lat3;
    exp_err = model_fault(s, a);
    if (!exp_err) begin
      if (r) exp_dout = model_read(s, g, a);
      else   model_write(s, a, d);
    end
    @(negedge clk);
    rw = r; sz = s; sgn = g; addr = a; din = d; en = 1'b1;
    lat1 = 0; lat3 = 0;
    for (int n = 1; n <= 40 && lat3 == 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        check({tag, " busy1"}, 32'(bus1.Busy), 32'd1);
        check({tag, " busy3"}, 32'(bus3.Busy), 32'd1);
        addr = $urandom; din = $urandom; rw = 1'($urandom_range(0, 1));
        sz = 2'($urandom_range(0, 3)); sgn = 1'($urandom_range(0, 1));
      end
      if (lat1 == 0 && bus1.MOC) lat1 = n - 1;
      if (lat3 == 0 && bus3.MOC) lat3 = n - 1;
    end
    check({tag, " lat1"}, 32'(lat1), 32'd2);
    check({tag, " lat3"}, 32'(lat3), 32'd4);
    check({tag, " moc1 hold"}, 32'(bus1.MOC), 32'd1);
    check({tag, " err1"}, 32'(bus1.AddrErr), 32'(exp_err));
    check({tag, " err3"}, 32'(bus3.AddrErr), 32'(exp_err));
    check({tag, " dout1"}, bus1.DataOut, exp_dout);
    check({tag, " dout3"}, bus3.DataOut, exp_dout);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk); #1;
    check({tag, " idle moc1"}, 32'(bus1.MOC), 32'd0);
    check({tag, " idle moc3"}, 32'(bus3.MOC), 32'd0);
    check({tag, " idle busy3"}, 32'(bus3.Busy), 32'd0);
    check({tag, " idle err3"}, 32'(bus3.AddrErr), 32'd0);
    check({tag, " idle dout1"}, bus1.DataOut, exp_dout);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " moc1"}, 32'(bus1.MOC), 32'd0);
    check({tag, " moc3"}, 32'(bus3.MOC), 32'd0);
    check({tag, " busy1"}, 32'(bus1.Busy), 32'd0);
    check({tag, " busy3"}, 32'(bus3.Busy), 32'd0);
    check({tag, " err1"}, 32'(bus1.AddrErr), 32'd0);
    check({tag, " err3"}, 32'(bus3.AddrErr), 32'd0);
    check({tag, " dout1"}, bus1.DataOut, 32'd0);
    check({tag, " dout3"}, bus3.DataOut, 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; rw = 1'b0; sz = 2'd0; sgn = 1'b0; addr = '0; din = '0;
    exp_dout = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill the low 128 bytes so every later in-range read is defined.
    for (int w = 0; w < 32; w++) access(1'b0, 2'd2, 1'b0, 32'(w * 4), $urandom, "fill");

    // Big-endian word write then readback, word and per byte.
    access(1'b0, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, "wr word");
    access(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, "rd word");
    check("rd word value", bus1.DataOut, 32'hDEADBEEF);
    access(1'b1, 2'd0, 1'b0, 32'h010, 32'h0, "rd b0");
    check("byte 0x10", bus1.DataOut, 32'h0000_00DE);
    access(1'b1, 2'd0, 1'b0, 32'h013, 32'h0, "rd b3");
    check("byte 0x13", bus1.DataOut, 32'h0000_00EF);

    // Extension of byte and halfword reads.
    access(1'b1, 2'd0, 1'b1, 32'h011, 32'h0, "rd byte s");
    check("byte signed", bus1.DataOut, 32'hFFFF_FFAD);
    access(1'b1, 2'd0, 1'b0, 32'h011, 32'h0, "rd byte u");
    check("byte unsigned", bus1.DataOut, 32'h0000_00AD);
    access(1'b1, 2'd1, 1'b1, 32'h012, 32'h0, "rd half s");
    check("half signed", bus1.DataOut, 32'hFFFF_BEEF);

    // Byte write touches only its lane.
    access(1'b0, 2'd0, 1'b0, 32'h013, 32'hFFFF_FF55, "wr byte");
    access(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, "rd merged");
    check("merged word", bus1.DataOut, 32'hDEADBE55);

    // Faults: misaligned half/word, out of range, reserved size.
    access(1'b1, 2'd1, 1'b0, 32'h011, 32'h0, "flt half");
    access(1'b0, 2'd2, 1'b0, 32'h012, 32'h1234_5678, "flt word wr");
    access(1'b1, 2'd2, 1'b0, 32'h200, 32'h0, "flt range");
    access(1'b0, 2'd3, 1'b0, 32'h010, 32'hCAFE_F00D, "flt size");
    access(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, "after flt");
    check("after flt value", bus1.DataOut, 32'hDEADBE55);

    // Reset while a write waits: the write is dropped and outputs clear.
    @(negedge clk);
    rw = 1'b0; sz = 2'd2; sgn = 1'b0; addr = 32'h010; din = 32'h1234_5678; en = 1'b1;
    @(posedge clk); #1;
    check("pre-abort busy1", 32'(bus1.Busy), 32'd1);
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(posedge clk); #1;
    exp_dout = 32'd0;
    check_quiet("abort");
    @(negedge clk);
    rst = 1'b0;
    access(1'b1, 2'd2, 1'b0, 32'h010, 32'h0, "post abort");
    check("post abort value", bus1.DataOut, 32'hDEADBE55);

    // Randomized mix of sizes, alignments and ranges.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] ra;
      if ($urandom_range(0, 9) == 0) ra = $urandom | 32'h0000_0200;
      else                           ra = 32'($urandom_range(0, 127));
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), ra, $urandom, $sformatf("rnd%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ram_sized_access_ctrl.md
Name: ram_sized_access_ctrl

Overview:
- Clocked, parametrised successor to the byte-addressed data RAM used by the CPU memory stage.
- Byte-wide storage array of configurable depth, accessed as byte, halfword or word in big-endian order.
- Adds a programmable wait-state counter, an Enable/MOC handshake with a defined FSM, zero/sign extension on reads, and address error detection (misaligned, out-of-range, reserved size).
- Sits between the control unit's memory interface and the datapath MDR.

Parameters:
- ADDR_W, 9, byte-address width used for indexing; depth = 2**ADDR_W bytes (default 512).
- WAIT_STATES, 1, extra cycles spent in WAIT before the access completes (0..15).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  request strobe; held high by master until MOC seen.
- ReadWrite  input  1  1 = read, 0 = write.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- Signed  input  1  read only: 1 = sign-extend byte/half, 0 = zero-extend.
- Address  input  32  byte address.
- DataIn  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- DataOut  output  32  read data, right-justified and extended.
- MOC  output  1  memory operation complete.
- Busy  output  1  high in WAIT and DONE.
- AddrErr  output  1  request faulted; valid while MOC high.

Behaviour:
- One clock; reset is synchronous and active-high. All state changes on rising Clk.
- Reset values: DataOut=0, MOC=0, Busy=0, AddrErr=0, FSM=IDLE, wait counter=0. Memory contents are not cleared.
- Reset mid-operation aborts the request. Any write not yet performed is dropped; reset has priority over all other events.
- FSM states IDLE, WAIT, DONE:
  - IDLE, Enable=1 at edge: latch ReadWrite, Size, Signed, Address, DataIn; load counter=WAIT_STATES; go WAIT; Busy=1.
  - WAIT, counter!=0: decrement.
  - WAIT, counter==0: perform access (or fault); go DONE; MOC=1.
  - DONE: hold MOC, DataOut and AddrErr while Enable=1. When Enable=0 at an edge: go IDLE, MOC=0, AddrErr=0, Busy=0. DataOut holds its last value.
- Latency: Enable sampled at edge N puts MOC high after edge N+1+WAIT_STATES.
- Inputs are latched at acceptance; changes during WAIT/DONE are ignored.
- Back-to-back requests need Enable low for at least one edge between requests.
- Byte ordering is big-endian. Word at A: Mem[A]=[31:24], A+1=[23:16], A+2=[15:8], A+3=[7:0]. Half at A: Mem[A]=[15:8], A+1=[7:0].
- Read extension: byte/half upper bits are filled with 0, or with bit 7/bit 15 when Signed=1. Signed is ignored for word and for writes.
- Fault conditions (AddrErr=1):
  - half with Address[0]=1;
  - word with Address[1:0]!=0;
  - Address >= 2**ADDR_W (any upper bit set);
  - Size=11.
- On a fault: no memory write, DataOut unchanged, MOC still asserted so the master never hangs.
- Writes modify only the addressed bytes. A read after a write to the same address returns the new data.

Test Plan:
- Reset, then write word 0xDEADBEEF at 0x010, read word at 0x010 -> DataOut=0xDEADBEEF; Mem[0x10..0x13]=DE,AD,BE,EF; MOC rises 2 edges after Enable (WAIT_STATES=1).
- Byte read 0x011 with Signed=1 -> 0xFFFFFFAD; with Signed=0 -> 0x000000AD. Half read 0x012 with Signed=1 -> 0xFFFFBEEF.
- Write byte 0x55 at 0x013, then read word 0x010 -> 0xDEADBE55; neighbouring bytes unchanged.
- Half read at 0x011, word write at 0x012, word access at 0x200 -> AddrErr=1 with MOC=1; memory and DataOut unchanged.
- WAIT_STATES=3: Enable held high -> MOC after exactly 4 edges; Address changed during WAIT -> original address used.
- Assert Reset during WAIT of a write -> MOC=0, Busy=0, FSM=IDLE, target bytes unchanged. Enable held low after MOC -> return to IDLE in one edge.
